// File: rtl/addr_decode_router.sv
// Single-master to N-slave request router with BASE/MASK address decode.
// Misses, slave errors and timeouts complete as bus-error responses.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   m_req_*             master request (valid/ready, addr, we, wdata, wstrb)
//   m_rsp_*             master response pulse (valid, rdata, err)
//   s_req_*             per-slave valid/ready, shared latched request fields
//   s_rsp_*             per-slave response valid, rdata slices, err
//   busy                transaction in flight
//   err_addr, err_count last errored address, saturating error count
module addr_decode_router #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NUM_SLAVES  = 3,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE =
        {32'h1000_0000, 32'h0000_1000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK =
        {32'hFFFF_FF00, 32'hFFFF_F000, 32'hFFFF_F000},
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         m_req_valid,
    output logic                         m_req_ready,
    input  logic [ADDR_W-1:0]            m_req_addr,
    input  logic                         m_req_we,
    input  logic [DATA_W-1:0]            m_req_wdata,
    input  logic [DATA_W/8-1:0]          m_req_wstrb,
    output logic                         m_rsp_valid,
    output logic [DATA_W-1:0]            m_rsp_rdata,
    output logic                         m_rsp_err,
    output logic [NUM_SLAVES-1:0]        s_req_valid,
    input  logic [NUM_SLAVES-1:0]        s_req_ready,
    output logic [ADDR_W-1:0]            s_req_addr,
    output logic                         s_req_we,
    output logic [DATA_W-1:0]            s_req_wdata,
    output logic [DATA_W/8-1:0]          s_req_wstrb,
    input  logic [NUM_SLAVES-1:0]        s_rsp_valid,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rsp_rdata,
    input  logic [NUM_SLAVES-1:0]        s_rsp_err,
    output logic                         busy,
    output logic [ADDR_W-1:0]            err_addr,
    output logic [7:0]                   err_count
);

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC);
    localparam int STB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_ERR  = 3'd3,
        S_RSP  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               we_q, we_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [STB_W-1:0]   wstrb_q, wstrb_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               rsp_err_q, rsp_err_d;
    logic [ADDR_W-1:0]  err_addr_q, err_addr_d;
    logic [7:0]         err_count_q, err_count_d;

    logic               hit;
    logic [SEL_W-1:0]   hit_idx;
    logic               sel_ready;
    logic               sel_rsp_valid;
    logic               sel_rsp_err;
    logic [DATA_W-1:0]  sel_rdata;
    logic               timeout;
    logic               err_evt;

    // Scan from the top index down so the lowest matching window wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((m_req_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
                SLV_BASE[i*ADDR_W +: ADDR_W]) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    // Only the latched target's handshake and response lines are looked at.
    always_comb begin
        sel_ready     = 1'b0;
        sel_rsp_valid = 1'b0;
        sel_rsp_err   = 1'b0;
        sel_rdata     = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_ready     = s_req_ready[i];
                sel_rsp_valid = s_rsp_valid[i];
                sel_rsp_err   = s_rsp_err[i];
                sel_rdata     = s_rsp_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign timeout = (timer_q == TMR_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        sel_d       = sel_q;
        timer_d     = timer_q;
        rdata_d     = rdata_q;
        rsp_err_d   = rsp_err_q;
        err_addr_d  = err_addr_q;
        err_count_d = err_count_q;
        err_evt     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (m_req_valid) begin
                    addr_d  = m_req_addr;
                    we_d    = m_req_we;
                    wdata_d = m_req_wdata;
                    wstrb_d = m_req_wstrb;
                    sel_d   = hit_idx;
                    timer_d = '0;
                    state_d = hit ? S_REQ : S_ERR;
                end
            end
            S_REQ: begin
                timer_d = timer_q + TMR_W'(1);
                // Timeout wins even if the slave accepts this same cycle.
                if (timeout) begin
                    rdata_d   = '0;
                    rsp_err_d = 1'b1;
                    err_evt   = 1'b1;
                    state_d   = S_RSP;
                end else if (sel_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                timer_d = timer_q + TMR_W'(1);
                if (timeout) begin
                    rdata_d   = '0;
                    rsp_err_d = 1'b1;
                    err_evt   = 1'b1;
                    state_d   = S_RSP;
                end else if (sel_rsp_valid) begin
                    rdata_d   = sel_rsp_err ? '0 : sel_rdata;
                    rsp_err_d = sel_rsp_err;
                    err_evt   = sel_rsp_err;
                    state_d   = S_RSP;
                end
            end
            S_ERR: begin
                rdata_d   = '0;
                rsp_err_d = 1'b1;
                err_evt   = 1'b1;
                state_d   = S_RSP;
            end
            S_RSP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (err_evt) begin
            err_addr_d = addr_q;
            if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            sel_q       <= '0;
            timer_q     <= '0;
            rdata_q     <= '0;
            rsp_err_q   <= 1'b0;
            err_addr_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            sel_q       <= sel_d;
            timer_q     <= timer_d;
            rdata_q     <= rdata_d;
            rsp_err_q   <= rsp_err_d;
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
        end
    end

    always_comb begin
        s_req_valid = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            s_req_valid[i] = (state_q == S_REQ) && (sel_q == SEL_W'(i));
        end
    end

    assign m_req_ready = (state_q == S_IDLE);
    assign m_rsp_valid = (state_q == S_RSP);
    assign m_rsp_rdata = (state_q == S_RSP) ? rdata_q : '0;
    assign m_rsp_err   = (state_q == S_RSP) && rsp_err_q;
    assign s_req_addr  = addr_q;
    assign s_req_we    = we_q;
    assign s_req_wdata = wdata_q;
    assign s_req_wstrb = wstrb_q;
    assign busy        = (state_q != S_IDLE);
    assign err_addr    = err_addr_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_addr_decode_router.sv
// Directed bench for addr_decode_router with a transaction-level model.
// Per-cycle compare against model expectations plus literal spot checks.
module tb_addr_decode_router;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 3;
    localparam int SW = DW / 8;
    localparam int TO = 8;
    localparam logic [NS*AW-1:0] BASES =
        {32'h1000_0000, 32'h0000_1000, 32'h0000_0000};
    localparam logic [NS*AW-1:0] MASKS =
        {32'hFFFF_FF00, 32'hFFFF_F000, 32'hFFFF_F000};

    logic              clk;
    logic              rst;
    logic              m_req_valid;
    logic              m_req_ready;
    logic [AW-1:0]     m_req_addr;
    logic              m_req_we;
    logic [DW-1:0]     m_req_wdata;
    logic [SW-1:0]     m_req_wstrb;
    logic              m_rsp_valid;
    logic [DW-1:0]     m_rsp_rdata;
    logic              m_rsp_err;
    logic [NS-1:0]     s_req_valid;
    logic [NS-1:0]     s_req_ready;
    logic [AW-1:0]     s_req_addr;
    logic              s_req_we;
    logic [DW-1:0]     s_req_wdata;
    logic [SW-1:0]     s_req_wstrb;
    logic [NS-1:0]     s_rsp_valid;
    logic [NS*DW-1:0]  s_rsp_rdata;
    logic [NS-1:0]     s_rsp_err;
    logic              busy;
    logic [AW-1:0]     err_addr;
    logic [7:0]        err_count;

    addr_decode_router #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_SLAVES(NS),
        .SLV_BASE(BASES), .SLV_MASK(MASKS), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
        .m_req_addr(m_req_addr), .m_req_we(m_req_we),
        .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb),
        .m_rsp_valid(m_rsp_valid), .m_rsp_rdata(m_rsp_rdata),
        .m_rsp_err(m_rsp_err),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
        .s_req_addr(s_req_addr), .s_req_we(s_req_we),
        .s_req_wdata(s_req_wdata), .s_req_wstrb(s_req_wstrb),
        .s_rsp_valid(s_rsp_valid), .s_rsp_rdata(s_rsp_rdata),
        .s_rsp_err(s_rsp_err),
        .busy(busy), .err_addr(err_addr), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] addr;
    } rsp_t;

    int            checks = 0;
    int            errors = 0;
    rsp_t          exp_q[$];
    logic [NS-1:0] exp_sreq;
    logic          exp_busy;
    logic          chk_en;
    logic [31:0]   cur_addr;
    logic          cur_we;
    logic [31:0]   cur_wdata;
    logic [3:0]    cur_wstrb;
    logic [31:0]   mdl_err_addr;
    int            mdl_err_cnt;

    function automatic int decode(input logic [31:0] a);
        logic [31:0] b;
        logic [31:0] m;
        for (int i = 0; i < NS; i++) begin
            b = BASES[i*AW +: AW];
            m = MASKS[i*AW +: AW];
            if ((a & m) == b) return i;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            rsp_t r;
            check("busy", 32'(busy), 32'(exp_busy));
            check("m_req_ready", 32'(m_req_ready), 32'(!exp_busy));
            check("s_req_valid", 32'(s_req_valid), 32'(exp_sreq));
            if (exp_sreq != '0) begin
                check("s_req_addr", s_req_addr, cur_addr);
                check("s_req_we", 32'(s_req_we), 32'(cur_we));
                check("s_req_wdata", s_req_wdata, cur_wdata);
                check("s_req_wstrb", 32'(s_req_wstrb), 32'(cur_wstrb));
            end
            if (m_rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got rsp_valid 1 expected 0");
                end else begin
                    r = exp_q.pop_front();
                    check("m_rsp_rdata", m_rsp_rdata, r.rdata);
                    check("m_rsp_err", 32'(m_rsp_err), 32'(r.err));
                    if (r.err) begin
                        mdl_err_addr = r.addr;
                        if (mdl_err_cnt < 255) mdl_err_cnt++;
                    end
                end
            end
            check("err_count", 32'(err_count), 32'(mdl_err_cnt));
            check("err_addr", err_addr, mdl_err_addr);
        end
    end

    task automatic clear_slaves();
        s_req_ready = '0;
        s_rsp_valid = '0;
        s_rsp_err   = '0;
        s_rsp_rdata = {NS{32'hBAD0_BAD0}};
    endtask

    // rdy: S_REQ cycle index at which slave raises ready (-1 = never)
    // rsp: S_WAIT cycle index at which slave responds (-1 = never)
    task automatic txn(input logic [31:0] a, input logic we,
                       input logic [31:0] wd, input logic [3:0] ws,
                       input int rdy, input int rsp,
                       input logic [31:0] rd, input logic serr,
                       input logic noise,
                       output int lat, output logic [31:0] got_rdata,
                       output logic got_err);
        int            sel;
        int            exp_lat;
        int            req_n;
        rsp_t          r;
        logic [NS-1:0] others;
        sel = decode(a);
        r.addr = a;
        if (sel < 0) begin
            exp_lat = 2;
            req_n   = 0;
            r.rdata = '0;
            r.err   = 1'b1;
        end else if (rdy >= 0 && rsp >= 0 && rdy + rsp + 2 < TO) begin
            exp_lat = rdy + rsp + 3;
            req_n   = rdy + 1;
            r.rdata = serr ? 32'h0 : rd;
            r.err   = serr;
        end else begin
            exp_lat = TO + 1;
            req_n   = (rdy < 0 || rdy >= TO - 1) ? TO : rdy + 1;
            r.rdata = '0;
            r.err   = 1'b1;
        end
        others = '1;
        if (sel >= 0) others[sel] = 1'b0;
        exp_q.push_back(r);
        m_req_valid = 1'b1;
        m_req_addr  = a;
        m_req_we    = we;
        m_req_wdata = wd;
        m_req_wstrb = ws;
        cur_addr    = a;
        cur_we      = we;
        cur_wdata   = wd;
        cur_wstrb   = ws;
        lat         = -1;
        got_rdata   = '0;
        got_err     = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            m_req_valid = 1'b0;
            m_req_addr  = ~a;
            m_req_wdata = ~wd;
            exp_busy    = (c < exp_lat);
            exp_sreq    = (sel >= 0 && c < req_n) ? NS'(1 << sel) : '0;
            clear_slaves();
            if (noise) begin
                s_req_ready = others;
                s_rsp_valid = others;
                s_rsp_err   = others;
            end
            if (sel >= 0 && rdy >= 0 && c >= rdy) s_req_ready[sel] = 1'b1;
            if (sel >= 0 && rdy >= 0 && rsp >= 0 && c == rdy + 1 + rsp) begin
                s_rsp_valid[sel]             = 1'b1;
                s_rsp_err[sel]               = serr;
                s_rsp_rdata[sel*DW +: DW]    = rd;
            end
            @(negedge clk);
            if (m_rsp_valid) begin
                lat       = c + 1;
                got_rdata = m_rsp_rdata;
                got_err   = m_rsp_err;
                break;
            end
        end
        check("latency", 32'(lat), 32'(exp_lat));
        @(posedge clk);
        #1;
        clear_slaves();
        exp_busy    = 1'b0;
        exp_sreq    = '0;
        m_req_addr  = '0;
        m_req_wdata = '0;
    endtask

    int          lat;
    logic [31:0] rd;
    logic        er;

    initial begin
        rst          = 1'b1;
        m_req_valid  = 1'b0;
        m_req_addr   = '0;
        m_req_we     = 1'b0;
        m_req_wdata  = '0;
        m_req_wstrb  = '0;
        clear_slaves();
        exp_sreq     = '0;
        exp_busy     = 1'b0;
        chk_en       = 1'b0;
        cur_addr     = '0;
        cur_we       = 1'b0;
        cur_wdata    = '0;
        cur_wstrb    = '0;
        mdl_err_addr = '0;
        mdl_err_cnt  = 0;

        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("rst_m_req_ready", 32'(m_req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_m_rsp_valid", 32'(m_rsp_valid), 32'd0);
        check("rst_s_req_valid", 32'(s_req_valid), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // DMEM read, immediate ready and response
        txn(32'h0000_1004, 1'b0, 32'h0, 4'h0, 0, 0,
            32'hDEAD_BEEF, 1'b0, 1'b0, lat, rd, er);
        check("t1_lat", 32'(lat), 32'd3);
        check("t1_rdata", rd, 32'hDEAD_BEEF);
        check("t1_err", 32'(er), 32'd0);

        // ASCON write, ready after 3 cycles
        txn(32'h1000_0010, 1'b1, 32'h0000_1234, 4'hF, 3, 0,
            32'h0, 1'b0, 1'b0, lat, rd, er);
        check("t2_lat", 32'(lat), 32'd6);
        check("t2_err", 32'(er), 32'd0);

        // Miss
        txn(32'h2000_0000, 1'b0, 32'h0, 4'h0, 0, 0,
            32'h0, 1'b0, 1'b0, lat, rd, er);
        check("t3_lat", 32'(lat), 32'd2);
        check("t3_err", 32'(er), 32'd1);
        check("t3_rdata", rd, 32'h0);
        check("t3_err_addr", err_addr, 32'h2000_0000);
        check("t3_err_count", 32'(err_count), 32'd1);

        // IMEM never ready: timeout, then a late response, then normal
        txn(32'h0000_0008, 1'b0, 32'h0, 4'h0, -1, 0,
            32'h0, 1'b0, 1'b0, lat, rd, er);
        check("t4_lat", 32'(lat), 32'd9);
        check("t4_err", 32'(er), 32'd1);
        check("t4_err_count", 32'(err_count), 32'd2);
        s_rsp_valid = 3'b001;
        s_rsp_rdata[31:0] = 32'h5555_5555;
        @(posedge clk);
        #1;
        clear_slaves();
        txn(32'h0000_0008, 1'b0, 32'h0, 4'h0, 0, 1,
            32'hCAFE_0008, 1'b0, 1'b0, lat, rd, er);
        check("t4b_lat", 32'(lat), 32'd4);
        check("t4b_rdata", rd, 32'hCAFE_0008);

        // Unselected slaves chatter the whole time
        txn(32'h0000_1ABC, 1'b1, 32'hA5A5_0001, 4'h3, 1, 2,
            32'h600D_F00D, 1'b0, 1'b1, lat, rd, er);
        check("noise_lat", 32'(lat), 32'd6);
        check("noise_rdata", rd, 32'h600D_F00D);

        // Timeout boundaries around the last usable timer value
        txn(32'h1000_00FC, 1'b0, 32'h0, 4'h0, 2, 3,
            32'h0000_7777, 1'b0, 1'b0, lat, rd, er);
        check("edge_ok_lat", 32'(lat), 32'd8);
        txn(32'h1000_00FC, 1'b0, 32'h0, 4'h0, 2, 4,
            32'h0000_7777, 1'b0, 1'b0, lat, rd, er);
        check("edge_to_err", 32'(er), 32'd1);
        txn(32'h0000_0100, 1'b0, 32'h0, 4'h0, TO - 1, 0,
            32'h0, 1'b0, 1'b0, lat, rd, er);
        check("rdy_at_to_lat", 32'(lat), 32'd9);

        // Slave error, then saturate the counter with misses
        txn(32'h0000_0010, 1'b0, 32'h0, 4'h0, 0, 0,
            32'h1111_1111, 1'b1, 1'b0, lat, rd, er);
        check("t5_err", 32'(er), 32'd1);
        check("t5_err_addr", err_addr, 32'h0000_0010);
        for (int i = 0; i < 256; i++) begin
            txn(32'h3000_0000 + 32'(i * 4), 1'b0, 32'h0, 4'h0, 0, 0,
                32'h0, 1'b0, 1'b0, lat, rd, er);
        end
        check("t5_sat", 32'(err_count), 32'd255);
        check("t5_sat_addr", err_addr, 32'h3000_03FC);

        // Reset while waiting for a response
        m_req_valid = 1'b1;
        m_req_addr  = 32'h0000_1008;
        m_req_we    = 1'b0;
        m_req_wdata = 32'h0;
        m_req_wstrb = 4'h0;
        cur_addr    = 32'h0000_1008;
        cur_we      = 1'b0;
        cur_wdata   = 32'h0;
        cur_wstrb   = 4'h0;
        @(posedge clk);
        #1;
        m_req_valid = 1'b0;
        exp_busy    = 1'b1;
        exp_sreq    = 3'b010;
        s_req_ready = 3'b010;
        @(posedge clk);
        #1;
        exp_sreq    = '0;
        s_req_ready = '0;
        rst         = 1'b1;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        exp_busy     = 1'b0;
        mdl_err_cnt  = 0;
        mdl_err_addr = '0;
        s_rsp_valid  = 3'b010;
        s_rsp_rdata[63:32] = 32'h7777_7777;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_err_count", 32'(err_count), 32'd0);
        check("t6_err_addr", err_addr, 32'h0);
        @(posedge clk);
        #1;
        clear_slaves();
        repeat (3) @(posedge clk);
        #1;
        txn(32'h2000_0040, 1'b0, 32'h0, 4'h0, 0, 0,
            32'h0, 1'b0, 1'b0, lat, rd, er);
        check("t6_after_cnt", 32'(err_count), 32'd1);
        check("t6_q_empty", 32'(exp_q.size()), 32'd0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
